// File: rtl/regfile.sv
// Register file with two combinational read ports, one write port and a per-register
// pending scoreboard. Optional same-cycle write forwarding when REGFILE_BYPASS_EN is defined.
module regfile #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy2,
  input  logic              iss_we,
  input  logic [ADDR_W-1:0] iss_rd
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_next;

  logic              re_v [2];
  logic [ADDR_W-1:0] ra_v [2];
  logic [DATA_W-1:0] rd_v [2];
  logic              bz_v [2];

  // Clear first, then set: an issuing writer to the same index wins over retirement.
  always_comb begin
    pending_next = pending;
    if (we && waddr != '0) pending_next[waddr] = 1'b0;
    if (iss_we && iss_rd != '0) pending_next[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      if (we && waddr != '0) regs[waddr] <= wdata;
      pending <= pending_next;
    end
  end

  assign re_v[0] = re1;
  assign re_v[1] = re2;
  assign ra_v[0] = raddr1;
  assign ra_v[1] = raddr2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_v[p] = '0;
      bz_v[p] = 1'b0;
      if (!rst && re_v[p] && ra_v[p] != '0) begin
`ifdef REGFILE_BYPASS_EN
        if (we && waddr == ra_v[p]) begin
          rd_v[p] = wdata;
        end else begin
          rd_v[p] = regs[ra_v[p]];
          bz_v[p] = pending[ra_v[p]];
        end
`else
        rd_v[p] = regs[ra_v[p]];
        bz_v[p] = pending[ra_v[p]];
`endif
      end
    end
  end

  assign rdata1 = rd_v[0];
  assign busy1  = bz_v[0];
  assign rdata2 = rd_v[1];
  assign busy2  = bz_v[1];

endmodule
